// File: rtl/ram_arbiter_2p.sv
// Two-client round-robin sequencer for a single-port synchronous RAM.
// One command in flight at a time; all outputs come straight from registers.
module ram_arbiter_2p #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk_arb,
  input  logic                  i_rst_arb,

  input  logic                  i_req0,
  input  logic                  i_we0,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [DATA_WIDTH-1:0] i_wdata0,
  output logic                  o_gnt0,
  output logic                  o_rvalid0,
  output logic [DATA_WIDTH-1:0] o_rdata0,

  input  logic                  i_req1,
  input  logic                  i_we1,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0] i_wdata1,
  output logic                  o_gnt1,
  output logic                  o_rvalid1,
  output logic [DATA_WIDTH-1:0] o_rdata1,

  output logic                  o_ram_en,
  output logic                  o_ram_we,
  output logic                  o_ram_re,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata,

  output logic                  o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RWAIT = 2'd2
  } state_e;

  state_e                state_q;
  logic                  prio_q;
  logic                  id_q;
  logic                  gnt0_q;
  logic                  gnt1_q;
  logic                  rvalid0_q;
  logic                  rvalid1_q;
  logic                  ram_en_q;
  logic                  ram_we_q;
  logic                  ram_re_q;
  logic                  busy_q;
  logic [DATA_WIDTH-1:0] rdata0_q;
  logic [DATA_WIDTH-1:0] rdata1_q;
  logic [DATA_WIDTH-1:0] ram_wdata_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;

  logic                  any_req_d;
  logic                  win_d;
  logic                  we_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;

  // prio_q = 1 hands a tie to client 1; a lone requester always wins.
  always_comb begin
    any_req_d = i_req0 | i_req1;
    win_d     = i_req1 & (~i_req0 | prio_q);
    we_d      = win_d ? i_we1    : i_we0;
    addr_d    = win_d ? i_addr1  : i_addr0;
    wdata_d   = win_d ? i_wdata1 : i_wdata0;
  end

  always_ff @(posedge i_clk_arb) begin
    if (i_rst_arb) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      id_q        <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
      busy_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      ram_en_q  <= 1'b0;
      ram_we_q  <= 1'b0;
      ram_re_q  <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (any_req_d) begin
            state_q     <= ISSUE;
            busy_q      <= 1'b1;
            id_q        <= win_d;
            prio_q      <= ~win_d;
            gnt0_q      <= ~win_d;
            gnt1_q      <= win_d;
            ram_en_q    <= 1'b1;
            ram_we_q    <= we_d;
            ram_re_q    <= ~we_d;
            ram_addr_q  <= addr_d;
            ram_wdata_q <= wdata_d;
          end
        end

        ISSUE: begin
          // ram_we_q still holds the command type during this cycle.
          if (ram_we_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= RWAIT;
          end
        end

        RWAIT: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (id_q) begin
            rdata1_q  <= i_ram_rdata;
            rvalid1_q <= 1'b1;
          end else begin
            rdata0_q  <= i_ram_rdata;
            rvalid0_q <= 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_gnt0      = gnt0_q;
  assign o_gnt1      = gnt1_q;
  assign o_rvalid0   = rvalid0_q;
  assign o_rvalid1   = rvalid1_q;
  assign o_rdata0    = rdata0_q;
  assign o_rdata1    = rdata1_q;
  assign o_ram_en    = ram_en_q;
  assign o_ram_we    = ram_we_q;
  assign o_ram_re    = ram_re_q;
  assign o_ram_addr  = ram_addr_q;
  assign o_ram_wdata = ram_wdata_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Directed bench for ram_arbiter_2p with a behavioural RAM and a read-data scoreboard.
module tb_ram_arbiter_2p;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, we0, req1, we1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic       ram_en, ram_we, ram_re, busy;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata = 8'h00;

  logic [7:0] mem [16];
  logic [7:0] exp_mem [16];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ram_arbiter_2p #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .i_clk_arb(clk), .i_rst_arb(rst),
    .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0),
    .o_gnt0(gnt0), .o_rvalid0(rvalid0), .o_rdata0(rdata0),
    .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1),
    .o_gnt1(gnt1), .o_rvalid1(rvalid1), .o_rdata1(rdata1),
    .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_re(ram_re),
    .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata),
    .o_busy(busy)
  );

  // Single-port RAM with one-cycle registered read data.
  always @(posedge clk) begin
    if (ram_en === 1'b1 && ram_we === 1'b1) mem[ram_addr] <= ram_wdata;
    if (ram_en === 1'b1 && ram_re === 1'b1) ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every read-data pulse must match the oldest outstanding read for that client.
  always @(negedge clk) begin
    if (rvalid0 === 1'b1) begin
      if (q0.size() == 0) chk("rvalid0_spurious", 32'(rvalid0), 32'd0);
      else chk("rdata0_sb", 32'(rdata0), 32'(q0.pop_front()));
    end
    if (rvalid1 === 1'b1) begin
      if (q1.size() == 0) chk("rvalid1_spurious", 32'(rvalid1), 32'd0);
      else chk("rdata1_sb", 32'(rdata1), 32'(q1.pop_front()));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_issue(input string tag, input bit c, input bit w,
                           input logic [3:0] a, input logic [7:0] d);
    chk({tag, "_gnt0"}, 32'(gnt0), 32'(!c));
    chk({tag, "_gnt1"}, 32'(gnt1), 32'(c));
    chk({tag, "_en"},   32'(ram_en), 32'd1);
    chk({tag, "_we"},   32'(ram_we), 32'(w));
    chk({tag, "_re"},   32'(ram_re), 32'(!w));
    chk({tag, "_addr"}, 32'(ram_addr), 32'(a));
    if (w) chk({tag, "_wdata"}, 32'(ram_wdata), 32'(d));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_en"},   32'(ram_en), 32'd0);
    chk({tag, "_we"},   32'(ram_we), 32'd0);
    chk({tag, "_re"},   32'(ram_re), 32'd0);
    chk({tag, "_gnt0"}, 32'(gnt0), 32'd0);
    chk({tag, "_gnt1"}, 32'(gnt1), 32'd0);
  endtask

  task automatic drive(input bit c, input bit r, input bit w,
                       input logic [3:0] a, input logic [7:0] d);
    if (c) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
  endtask

  task automatic write_tx(input string tag, input bit c, input logic [3:0] a, input logic [7:0] d);
    drive(c, 1'b1, 1'b1, a, d);
    exp_mem[a] = d;
    step();
    chk_issue(tag, c, 1'b1, a, d);
    drive(c, 1'b0, 1'b0, a, d);
    step();
    chk_quiet({tag, "_after"});
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic read_tx(input string tag, input bit c, input logic [3:0] a);
    drive(c, 1'b1, 1'b0, a, 8'h00);
    if (c) q1.push_back(exp_mem[a]); else q0.push_back(exp_mem[a]);
    step();
    chk_issue(tag, c, 1'b0, a, 8'h00);
    drive(c, 1'b0, 1'b0, a, 8'h00);
    step();
    chk_quiet({tag, "_rwait"});
    chk({tag, "_rwait_busy"}, 32'(busy), 32'd1);
    step();
    chk({tag, "_rvalid0"}, 32'(rvalid0), 32'(!c));
    chk({tag, "_rvalid1"}, 32'(rvalid1), 32'(c));
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    step();
    chk({tag, "_rvalid_drop"}, 32'(rvalid0 | rvalid1), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_quiet(tag);
    chk({tag, "_rvalid0"}, 32'(rvalid0), 32'd0);
    chk({tag, "_rvalid1"}, 32'(rvalid1), 32'd0);
    chk({tag, "_rdata0"},  32'(rdata0), 32'd0);
    chk({tag, "_rdata1"},  32'(rdata1), 32'd0);
    chk({tag, "_addr"},    32'(ram_addr), 32'd0);
    chk({tag, "_wdata"},   32'(ram_wdata), 32'd0);
    chk({tag, "_busy"},    32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin mem[i] = 8'h00; exp_mem[i] = 8'h00; end

    // Reset held two cycles with random client inputs.
    rst = 1'b1;
    req0 = 1'($urandom); we0 = 1'($urandom); addr0 = 4'($urandom); wdata0 = 8'($urandom);
    req1 = 1'($urandom); we1 = 1'($urandom); addr1 = 4'($urandom); wdata1 = 8'($urandom);
    step();
    req0 = 1'($urandom); req1 = 1'($urandom);
    step();
    chk_all_zero("reset");
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    step();
    chk_all_zero("post_reset_idle");

    // Client 0 write, then client 1 reads it back.
    write_tx("c0_wr3", 1'b0, 4'd3, 8'h5A);
    read_tx("c1_rd3", 1'b1, 4'd3);
    chk("c1_rd3_rdata1", 32'(rdata1), 32'h5A);
    chk("c1_rd3_rdata0_kept", 32'(rdata0), 32'h00);

    // Both clients hold writes; expect grants 0,1,0,1.
    drive(1'b0, 1'b1, 1'b1, 4'd0, 8'h11);
    drive(1'b1, 1'b1, 1'b1, 4'd1, 8'h22);
    step();
    chk_issue("tie_g1", 1'b0, 1'b1, 4'd0, 8'h11);
    drive(1'b0, 1'b1, 1'b1, 4'd0, 8'h33);
    step();
    chk_quiet("tie_i1");
    step();
    chk_issue("tie_g2", 1'b1, 1'b1, 4'd1, 8'h22);
    drive(1'b1, 1'b1, 1'b1, 4'd1, 8'h44);
    step();
    chk_quiet("tie_i2");
    step();
    chk_issue("tie_g3", 1'b0, 1'b1, 4'd0, 8'h33);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    step();
    chk_quiet("tie_i3");
    step();
    chk_issue("tie_g4", 1'b1, 1'b1, 4'd1, 8'h44);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    step();
    chk_quiet("tie_i4");
    exp_mem[0] = 8'h33;
    exp_mem[1] = 8'h44;
    read_tx("rb_a0", 1'b0, 4'd0);
    chk("rb_a0_rdata0", 32'(rdata0), 32'h33);
    read_tx("rb_a1", 1'b1, 4'd1);
    chk("rb_a1_rdata1", 32'(rdata1), 32'h44);

    // Reset during RWAIT discards the read and restores client-0 priority.
    drive(1'b0, 1'b1, 1'b0, 4'd0, 8'h00);
    step();
    chk_issue("rst_rd", 1'b0, 1'b0, 4'd0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    step();
    chk("rst_rwait_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    chk_all_zero("rst_mid");
    rst = 1'b0;
    step();
    chk("rst_no_rvalid0", 32'(rvalid0), 32'd0);
    drive(1'b0, 1'b1, 1'b1, 4'd5, 8'hA5);
    drive(1'b1, 1'b1, 1'b1, 4'd6, 8'hB6);
    exp_mem[5] = 8'hA5;
    exp_mem[6] = 8'hB6;
    step();
    chk_issue("rst_tie_g1", 1'b0, 1'b1, 4'd5, 8'hA5);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    step();
    chk_quiet("rst_tie_i1");
    step();
    chk_issue("rst_tie_g2", 1'b1, 1'b1, 4'd6, 8'hB6);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    step();
    chk_quiet("rst_tie_i2");

    // Back-to-back write then read of addr 15 with request kept high.
    drive(1'b0, 1'b1, 1'b1, 4'd15, 8'hFF);
    exp_mem[15] = 8'hFF;
    step();
    chk_issue("b2b_wr", 1'b0, 1'b1, 4'd15, 8'hFF);
    drive(1'b0, 1'b1, 1'b0, 4'd15, 8'h00);
    q0.push_back(8'hFF);
    step();
    chk_quiet("b2b_idle");
    step();
    chk_issue("b2b_rd", 1'b0, 1'b0, 4'd15, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    step();
    chk_quiet("b2b_rwait");
    step();
    chk("b2b_rvalid0", 32'(rvalid0), 32'd1);
    chk("b2b_rdata0", 32'(rdata0), 32'hFF);
    step();
    chk("b2b_rvalid0_drop", 32'(rvalid0), 32'd0);
    chk("b2b_rdata0_hold", 32'(rdata0), 32'hFF);
    step();

    chk("sb_q0_empty", 32'(q0.size()), 32'd0);
    chk("sb_q1_empty", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_arbiter_2p.md
Name: ram_arbiter_2p

Overview:
- Two-requester round-robin arbiter and sequencer for the team's single-port synchronous RAM (en/we/re, addr, wdata, 1-cycle registered rdata).
- Two clients share one RAM instance. The block issues one RAM command at a time, pulses a grant to the served client and returns read data with a valid pulse.
- It sits directly between the client logic and the RAM ports.

Parameters:
- DATA_WIDTH, 8: data width of RAM and client data buses.
- ADDR_WIDTH, 4: address width of RAM and client address buses.

Ports:
- i_clk_arb  in  1  clock. All logic on its rising edge.
- i_rst_arb  in  1  reset, synchronous, active-high.
- i_req0  in  1  client 0 request. Held high with command stable until o_gnt0.
- i_we0  in  1  client 0 command: 1 = write, 0 = read.
- i_addr0  in  ADDR_WIDTH  client 0 address.
- i_wdata0  in  DATA_WIDTH  client 0 write data.
- o_gnt0  out  1  one-cycle pulse: client 0 command is on the RAM this cycle.
- o_rvalid0  out  1  one-cycle pulse: o_rdata0 holds client 0 read data.
- o_rdata0  out  DATA_WIDTH  client 0 read data. Holds its value until the next client 0 read.
- i_req1, i_we1, i_addr1, i_wdata1, o_gnt1, o_rvalid1, o_rdata1: same as the client 0 ports, for client 1.
- o_ram_en  out  1  RAM enable.
- o_ram_we  out  1  RAM write enable.
- o_ram_re  out  1  RAM read enable.
- o_ram_addr  out  ADDR_WIDTH  RAM address.
- o_ram_wdata  out  DATA_WIDTH  RAM write data.
- i_ram_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after en&re.
- o_busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- All outputs are registered. There is no combinational path from inputs to outputs.
- Reset values: every output 0, FSM in IDLE, round-robin pointer favours client 0.
- FSM states:
  - IDLE: if any request is high, select the winner, latch its we/addr/wdata and client id, and go to ISSUE. Otherwise stay.
  - ISSUE: RAM outputs carry the latched command.
    - Write: o_ram_en=1, o_ram_we=1, o_ram_re=0. Next state IDLE.
    - Read: o_ram_en=1, o_ram_re=1, o_ram_we=0. Next state RWAIT.
    - o_gnt of the winner is 1 during this cycle.
  - RWAIT: all RAM enables 0. On the closing edge, capture i_ram_rdata into the winner's o_rdata, pulse its o_rvalid for the following cycle, and go to IDLE.
- Outside ISSUE: o_ram_en, o_ram_we and o_ram_re are 0. o_ram_addr and o_ram_wdata hold their last value.
- Latency, request seen in IDLE at cycle N:
  - Grant and RAM command at cycle N+1.
  - Write returns to IDLE at N+2.
  - Read: rvalid/rdata at N+3, which is also an IDLE cycle, so a new arbitration may start then.
- Arbitration:
  - One request only: that client wins.
  - Both requesting: the client not served last wins. The pointer updates on every grant.
  - First tie after reset goes to client 0.
- Command sampling: client inputs are sampled only in IDLE, on the winning edge. Changes during ISSUE or RWAIT are ignored.
- A request still high in the IDLE cycle after its grant counts as a new request. Clients drop i_req on the edge after o_gnt.
- Simultaneous events: o_rvalid for one client and an arbitration decision in the same IDLE cycle are both legal and independent.
- Reset mid-operation (any state):
  - Next cycle all outputs are 0 and the FSM is in IDLE.
  - An in-flight read is discarded and no o_rvalid is issued.
  - The pointer returns to favouring client 0.
- Throughput:
  - Writes: one per 2 cycles.
  - Reads: one per 3 cycles.
  - Continuous ties alternate 0,1,0,1.

Test Plan:
- Reset: hold i_rst_arb 2 cycles with random inputs -> all outputs 0, o_busy=0.
- Client 0 write, addr 3, data 0x5A, req at cycle N -> at N+1: o_gnt0=1, o_ram_en=1, o_ram_we=1, o_ram_addr=3, o_ram_wdata=0x5A, o_ram_re=0. At N+2: all enables 0.
- Client 1 read, addr 3, after the prior write -> o_gnt1 at N+1 with o_ram_re=1. At N+3: o_rvalid1=1 for one cycle, o_rdata1=0x5A. o_rvalid0 stays 0 and o_rdata0 is unchanged.
- Both clients hold write requests (c0 writes addr 0, c1 writes addr 1, data 0x11/0x22/0x33/0x44, reloading after each grant) -> grant order 0,1,0,1. Readback of addr 0 returns 0x33 and addr 1 returns 0x44.
- Reset asserted during RWAIT of a client 0 read -> no o_rvalid0. All outputs 0 the next cycle. Then a simultaneous c0/c1 request grants client 0 first.
- Client 0 writes addr 15 = 0xFF, then client 0 reads addr 15 back-to-back (req kept high, command changed after the grant) -> second grant at write-IDLE+1, o_rdata0=0xFF, o_rvalid0 pulse exactly 1 cycle.
